// File: rtl/wb_arb_pkg.sv
// Shared defaults for the register-file write-back arbiter: geometry, grant counter width and saturation.
package wb_arb_pkg;

  localparam int N_REQ_DEF = 3;
  localparam int AW_DEF    = 4;
  localparam int DW_DEF    = 16;

  localparam int               CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // A pairing grant accepts two requesters in one cycle, so the increment is 0..2.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
    return (sum > {1'b0, CNT_MAX}) ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/rr_find_first.sv
// Rotating priority encoder: first set bit of (i_req & i_mask) searching upward from i_start, wrapping at N.
// Purely combinational; i_start must be below N.
module rr_find_first #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_mask,
  input  logic [IW-1:0] i_start,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  logic [N-1:0] w_elig;

  assign w_elig = i_req & i_mask;

  always_comb begin
    logic [IW:0] pos;
    o_found = 1'b0;
    o_idx   = '0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, i_start} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end
      if (!o_found && w_elig[pos[IW-1:0]]) begin
        o_found = 1'b1;
        o_idx   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter feeding the 16x16 register file; grant is combinational, write controls appear one cycle later.
// Define WB_ARB_PAIR_EN to let a second op2=0 requester share the cycle on port 2.
module regfile_wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_op2,
  input  logic [N_REQ*AW-1:0] req_waddr1,
  input  logic [N_REQ*AW-1:0] req_waddr2,
  input  logic [N_REQ*DW-1:0] req_wdata1,
  input  logic [N_REQ*DW-1:0] req_wdata2,
  output logic [N_REQ-1:0]    req_ready,
  output logic [AW-1:0]       WriteReg1,
  output logic [AW-1:0]       WriteReg2,
  output logic [DW-1:0]       WriteData1,
  output logic [DW-1:0]       WriteData2,
  output logic                RegWrite,
  output logic                WriteOP2,
  output logic [CNT_W-1:0]    grant_cnt
);

  localparam int IW = $clog2(N_REQ);

  function automatic logic [IW-1:0] f_wrap_inc(input logic [IW-1:0] idx);
    return (idx == IW'(N_REQ-1)) ? '0 : idx + IW'(1);
  endfunction

  logic [AW-1:0] w_waddr1 [N_REQ];
  logic [AW-1:0] w_waddr2 [N_REQ];
  logic [DW-1:0] w_wdata1 [N_REQ];
  logic [DW-1:0] w_wdata2 [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_waddr1[g] = req_waddr1[g*AW +: AW];
    assign w_waddr2[g] = req_waddr2[g*AW +: AW];
    assign w_wdata1[g] = req_wdata1[g*DW +: DW];
    assign w_wdata2[g] = req_wdata2[g*DW +: DW];
  end

  logic [IW-1:0]    r_rr_ptr;
  logic             r_we;
  logic             r_op2;
  logic [AW-1:0]    r_wreg1;
  logic [AW-1:0]    r_wreg2;
  logic [DW-1:0]    r_wdat1;
  logic [DW-1:0]    r_wdat2;
  logic [CNT_W-1:0] r_cnt;

  logic             w_pri_found;
  logic [IW-1:0]    w_pri_idx;
  logic [IW-1:0]    w_pri_next;
  logic [N_REQ-1:0] w_pri_onehot;
  logic             w_grant;
  logic             w_pair;
  logic [IW-1:0]    w_sec_idx;
  logic [1:0]       w_inc;

  rr_find_first #(
    .N  (N_REQ),
    .IW (IW)
  ) u_find_pri (
    .i_req   (req_valid),
    .i_mask  ({N_REQ{1'b1}}),
    .i_start (r_rr_ptr),
    .o_found (w_pri_found),
    .o_idx   (w_pri_idx)
  );

  assign w_grant      = rst && w_pri_found;
  assign w_pri_next   = f_wrap_inc(w_pri_idx);
  assign w_pri_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_pri_idx;

`ifdef WB_ARB_PAIR_EN
  logic w_sec_found;

  // Continue the round-robin walk past the primary, considering only single-write requesters.
  rr_find_first #(
    .N  (N_REQ),
    .IW (IW)
  ) u_find_sec (
    .i_req   (req_valid & ~req_op2),
    .i_mask  (~w_pri_onehot),
    .i_start (w_pri_next),
    .o_found (w_sec_found),
    .o_idx   (w_sec_idx)
  );

  // Same destination as the primary would race on the two ports; the partner waits instead.
  assign w_pair = w_grant && !req_op2[w_pri_idx] && w_sec_found &&
                  (w_waddr1[w_sec_idx] != w_waddr1[w_pri_idx]);
`else
  assign w_pair    = 1'b0;
  assign w_sec_idx = '0;
`endif

  always_comb begin
    req_ready = '0;
    if (w_grant) begin
      req_ready = w_pri_onehot;
    end
    if (w_pair) begin
      req_ready = req_ready | ({{(N_REQ-1){1'b0}}, 1'b1} << w_sec_idx);
    end
  end

  assign w_inc = w_grant ? (w_pair ? 2'd2 : 2'd1) : 2'd0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr_ptr <= '0;
      r_we     <= 1'b0;
      r_op2    <= 1'b0;
      r_wreg1  <= '0;
      r_wreg2  <= '0;
      r_wdat1  <= '0;
      r_wdat2  <= '0;
      r_cnt    <= '0;
    end else begin
      r_we  <= w_grant;
      r_op2 <= w_grant && (req_op2[w_pri_idx] || w_pair);
      r_cnt <= sat_add(r_cnt, w_inc);
      if (w_grant) begin
        r_rr_ptr <= w_pri_next;
        r_wreg1  <= w_waddr1[w_pri_idx];
        r_wdat1  <= w_wdata1[w_pri_idx];
        if (req_op2[w_pri_idx]) begin
          r_wreg2 <= w_waddr2[w_pri_idx];
          r_wdat2 <= w_wdata2[w_pri_idx];
        end else if (w_pair) begin
          r_wreg2 <= w_waddr1[w_sec_idx];
          r_wdat2 <= w_wdata1[w_sec_idx];
        end
      end
    end
  end

  assign WriteReg1  = r_wreg1;
  assign WriteReg2  = r_wreg2;
  assign WriteData1 = r_wdat1;
  assign WriteData2 = r_wdat2;
  assign RegWrite   = r_we;
  assign WriteOP2   = r_op2;
  assign grant_cnt  = r_cnt;

endmodule
